sweep_sequencer: RTL and testbench

- Controller that sequences an up/down counter through repeated ping-pong sweeps between programmable limits `lo` and `hi`.
- Selects direction, paces steps with a per-direction prescaler, and tracks the shadow position. Finite or endless sweep counts.
- Sits between the top-level switch/config inputs and the counter: drives the counter's `dir` and a one-cycle `step` enable instead of a divided clock.

---
 rtl/sweep_pkg.sv | 22 ++
 rtl/prescale_tick.sv | 41 ++++
 rtl/sweep_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the ping-pong sweep sequencer.
// Holds the FSM state encoding, direction constants and default widths.
package sweep_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 16;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2,
    FINISH = 2'd3
  } state_e;

  function automatic logic is_run(input state_e s);
    return (s == RUN_UP) || (s == RUN_DN);
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Step pacer: counts enabled cycles and emits a one-cycle tick when the count
// reaches the terminal value, clearing itself on the same edge.
module prescale_tick
  import sweep_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] term,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // A pending clear suppresses the tick so an abort never produces a step.
  assign tick = en && !clr && (cnt_q == term);

  // NOTE: cnt_d gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Drives an up/down counter through ping-pong sweeps between latched limits,
// issuing dir plus a paced one-cycle step enable and tracking the position.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [7:0]       sweeps,
  input  logic [PRE_W-1:0] pre_up,
  input  logic [PRE_W-1:0] pre_dn,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [7:0]       sweeps_q, sweeps_d;
  logic [7:0]       sweep_cnt_q, sweep_cnt_d;
  logic [PRE_W-1:0] pre_up_q, pre_up_d;
  logic [PRE_W-1:0] pre_dn_q, pre_dn_d;

  logic             run;
  logic             tick;
  logic [PRE_W-1:0] term;
  logic [WIDTH-1:0] pos_inc;
  logic [WIDTH-1:0] pos_dec;

  assign run     = is_run(state_q);
  assign term    = (state_q == RUN_DN) ? pre_dn_q : pre_up_q;
  assign pos_inc = pos_q + WIDTH'(1);
  assign pos_dec = pos_q - WIDTH'(1);

  // Counter is held at zero outside the run states, so each run starts fresh.
  prescale_tick #(
    .PRE_W (PRE_W)
  ) u_pace (
    .clk   (clk),
    .reset (reset),
    .clr   (abort || !run),
    .en    (run),
    .term  (term),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    pre_up_d    = pre_up_q;
    pre_dn_d    = pre_dn_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (lo < hi) begin
            lo_d        = lo;
            hi_d        = hi;
            sweeps_d    = sweeps;
            pre_up_d    = pre_up;
            pre_dn_d    = pre_dn;
            pos_d       = lo;
            dir_d       = DIR_UP;
            sweep_cnt_d = sweeps;
            busy_d      = 1'b1;
            state_d     = RUN_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN_UP: begin
        if (tick) begin
          pos_d = pos_inc;
          if (pos_inc == hi_q) begin
            dir_d   = DIR_DN;
            state_d = RUN_DN;
          end
        end
      end

      RUN_DN: begin
        if (tick) begin
          pos_d = pos_dec;
          // Arriving back at lo closes one full lo->hi->lo sweep.
          if (pos_dec == lo_q) begin
            if (sweeps_q == 8'd0) begin
              dir_d   = DIR_UP;
              state_d = RUN_UP;
            end else if (sweep_cnt_q == 8'd1) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              sweep_cnt_d = sweep_cnt_q - 8'd1;
              dir_d       = DIR_UP;
              state_d     = RUN_UP;
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything; pos and dir simply hold.
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      dir_q       <= DIR_UP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      pre_up_q    <= '0;
      pre_dn_q    <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      pre_up_q    <= pre_up_d;
      pre_dn_q    <= pre_dn_d;
    end
  end

  assign step = tick;
  assign dir  = dir_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: expected steps are queued when a run
// is launched and compared (pos, dir, spacing) as the DUT issues them.
module tb_sweep_sequencer;

  localparam int WIDTH = 4;
  localparam int PRE_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [7:0]       sweeps;
  logic [PRE_W-1:0] pre_up;
  logic [PRE_W-1:0] pre_dn;
  logic             step;
  logic             dir;
  logic [WIDTH-1:0] pos;
  logic             busy;
  logic             done;
  logic             err;

  sweep_sequencer #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .lo     (lo),
    .hi     (hi),
    .sweeps (sweeps),
    .pre_up (pre_up),
    .pre_dn (pre_dn),
    .step   (step),
    .dir    (dir),
    .pos    (pos),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pos;
    logic             dir;
    int               gap;
  } step_t;

  step_t            exp_q[$];
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               last_step_cyc = 0;
  int               done_cnt = 0;
  int               d0;
  logic             pend = 1'b0;
  logic [WIDTH-1:0] pend_pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every step must match the head of the expected queue.
  always @(negedge clk) begin : mon
    step_t e;
    cyc++;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (pend) begin
        check("step_pos", 32'(pos), 32'(pend_pos));
        pend = 1'b0;
      end
      if (step) begin
        check("step_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("step_dir", 32'(dir), 32'(e.dir));
          if (e.gap != 0) check("step_gap", cyc - last_step_cyc, e.gap);
          pend     = 1'b1;
          pend_pos = e.pos;
        end
        check("step_busy", 32'(busy), 1);
        last_step_cyc = cyc;
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_run(input int l, input int h, input int nsw, input int pu, input int pd);
    for (int s = 0; s < nsw; s++) begin
      for (int p = l + 1; p <= h; p++) exp_q.push_back('{4'(p), 1'b1, pu + 1});
      for (int p = h - 1; p >= l; p--) exp_q.push_back('{4'(p), 1'b0, pd + 1});
    end
  endtask

  task automatic start_run(input int l, input int h, input int nsw, input int pu, input int pd);
    lo     = 4'(l);
    hi     = 4'(h);
    sweeps = 8'(nsw);
    pre_up = 16'(pu);
    pre_dn = 16'(pd);
    start  = 1'b1;
    clk_n(1);
    start = 1'b0;
    last_step_cyc = cyc;
    check("busy_on", 32'(busy), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      clk_n(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    lo     = '0;
    hi     = '0;
    sweeps = '0;
    pre_up = '0;
    pre_dn = '0;
    #12;
    check("rst_step", 32'(step), 0);
    check("rst_dir",  32'(dir),  1);
    check("rst_pos",  32'(pos),  0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err",  32'(err),  0);
    @(negedge clk);
    reset = 1'b0;
    clk_n(2);

    // Basic sweep 2..5, one step per cycle.
    d0 = done_cnt;
    push_run(2, 5, 1, 0, 0);
    start_run(2, 5, 1, 0, 0);
    drain(50);
    clk_n(4);
    check("basic_done", done_cnt - d0, 1);
    check("basic_busy", 32'(busy), 0);
    check("basic_pos",  32'(pos),  2);

    // Asymmetric pacing: up every 4 cycles, down every 2.
    d0 = done_cnt;
    push_run(0, 3, 1, 3, 1);
    start_run(0, 3, 1, 3, 1);
    drain(100);
    clk_n(4);
    check("pace_done", done_cnt - d0, 1);
    check("pace_busy", 32'(busy), 0);

    // Three sweeps then done.
    d0 = done_cnt;
    push_run(4, 6, 3, 0, 0);
    start_run(4, 6, 3, 0, 0);
    drain(100);
    clk_n(4);
    check("multi_done", done_cnt - d0, 1);
    check("multi_pos",  32'(pos),  4);

    // Endless: ten sweeps without done, then abort.
    d0 = done_cnt;
    push_run(1, 3, 10, 1, 1);
    start_run(1, 3, 0, 1, 1);
    drain(300);
    abort = 1'b1;
    clk_n(1);
    abort = 1'b0;
    check("endless_abort_busy", 32'(busy), 0);
    clk_n(4);
    check("endless_done", done_cnt - d0, 0);
    check("endless_pos",  32'(pos),  1);

    // Rejected starts.
    lo = 4'd7; hi = 4'd7; start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("rej_eq_err",  32'(err),  1);
    check("rej_eq_busy", 32'(busy), 0);
    clk_n(1);
    check("rej_err_pulse", 32'(err), 0);
    lo = 4'd9; hi = 4'd3; start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("rej_gt_err", 32'(err), 1);
    lo = 4'd1; hi = 4'd5; start = 1'b1; abort = 1'b1;
    clk_n(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_err",  32'(err),  0);
    check("start_abort_busy", 32'(busy), 0);
    clk_n(2);
    check("start_abort_idle", 32'(busy), 0);

    // Abort once pos reaches 4.
    d0 = done_cnt;
    exp_q.push_back('{4'd3, 1'b1, 2});
    exp_q.push_back('{4'd4, 1'b1, 2});
    start_run(2, 6, 1, 1, 1);
    drain(50);
    abort = 1'b1;
    clk_n(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    clk_n(4);
    check("abort_pos",  32'(pos), 4);
    check("abort_done", done_cnt - d0, 0);

    // Async reset in the middle of a down-step cycle.
    push_run(0, 2, 1, 2, 2);
    void'(exp_q.pop_back());
    start_run(0, 2, 1, 2, 2);
    drain(50);
    clk_n(2);
    check("pre_rst_step", 32'(step), 1);
    check("pre_rst_dir",  32'(dir),  0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_step", 32'(step), 0);
    check("arst_dir",  32'(dir),  1);
    check("arst_pos",  32'(pos),  0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_err",  32'(err),  0);
    @(negedge clk);
    reset = 1'b0;
    clk_n(2);
    check("arst_idle", 32'(busy), 0);

    // Input changes and start while busy are ignored.
    d0 = done_cnt;
    push_run(1, 4, 1, 1, 0);
    start_run(1, 4, 1, 1, 0);
    clk_n(3);
    hi = 4'd8; pre_up = 16'd5; sweeps = 8'd2; lo = 4'd0;
    start = 1'b1;
    clk_n(3);
    start = 1'b0;
    drain(100);
    clk_n(6);
    check("ign_done", done_cnt - d0, 1);
    check("ign_busy", 32'(busy), 0);
    check("ign_pos",  32'(pos),  1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
